memory_access: RTL and testbench

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/memory_access.sv | 182 ++++++++++++++++++
 tb/tb_memory_access.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// Load/store stage: issues one data-bus request per memory op, aligns store data,
// extracts and extends load data, and forwards ALU results for non-memory ops.
module memory_access #(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  minst_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rd_i,
    input  logic        rdm_v_i,
    output logic        stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        wb_v_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        err_o
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      state_reg;
    logic [2:0]  funct3_reg;
    logic [1:0]  off_reg;
    logic [4:0]  rd_reg;
    logic        rdm_v_reg;
    logic        req_reg, we_reg;
    logic [31:0] addr_reg, wdata_reg;
    logic [3:0]  be_reg;
    logic        wb_v_reg, err_reg;
    logic [4:0]  wb_rd_reg;
    logic [31:0] wb_data_reg;

    // Input decode; size is minst_i[1:0] for both loads (funct3[1:0]) and stores
    logic        is_mem, is_load, is_store, reserved, misaligned;
    logic [1:0]  size, eff_off;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;

    assign is_mem   = (minst_i[3:2] != 2'b11);
    assign is_load  = ~minst_i[3];
    assign is_store = (minst_i[3:2] == 2'b10);
    assign size     = minst_i[1:0];
    assign reserved = is_mem && ((size == 2'b11) || (is_load && minst_i[2:0] == 3'b110));
    assign misaligned = ALIGN_CHECK &&
                        (((size == 2'b01) && addr_i[0]) ||
                         ((size == 2'b10) && (addr_i[1:0] != 2'b00)));

    // Masking the offset by size makes ALIGN_CHECK=0 ignore the sub-size address bits
    always_comb begin
        eff_off    = 2'b00;
        be_next    = 4'b1111;
        wdata_next = wdata_i;
        case (size)
            2'b00: begin
                eff_off    = addr_i[1:0];
                be_next    = 4'b0001 << addr_i[1:0];
                wdata_next = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                eff_off    = {addr_i[1], 1'b0};
                be_next    = 4'b0011 << {addr_i[1], 1'b0};
                wdata_next = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    logic [7:0]  rd_bytes [4];
    logic [15:0] half_sel;
    logic [31:0] load_val;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_bytes[gi] = dmem_rdata_i[8*gi +: 8];
        end
    endgenerate

    assign half_sel = off_reg[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];

    always_comb begin
        load_val = dmem_rdata_i;
        case (funct3_reg)
            3'b000:  load_val = {{24{rd_bytes[off_reg][7]}}, rd_bytes[off_reg]};
            3'b100:  load_val = {24'h0, rd_bytes[off_reg]};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_val = {16'h0, half_sel};
            default: load_val = dmem_rdata_i;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            funct3_reg  <= 3'b0;
            off_reg     <= 2'b0;
            rd_reg      <= 5'b0;
            rdm_v_reg   <= 1'b0;
            req_reg     <= 1'b0;
            we_reg      <= 1'b0;
            addr_reg    <= 32'h0;
            be_reg      <= 4'b0;
            wdata_reg   <= 32'h0;
            wb_v_reg    <= 1'b0;
            wb_rd_reg   <= 5'b0;
            wb_data_reg <= 32'h0;
            err_reg     <= 1'b0;
        end else begin
            wb_v_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (is_mem) begin
                        if (reserved || misaligned) begin
                            err_reg <= 1'b1;
                        end else begin
                            state_reg  <= REQ;
                            req_reg    <= 1'b1;
                            we_reg     <= is_store;
                            addr_reg   <= {addr_i[31:2], 2'b00};
                            be_reg     <= be_next;
                            wdata_reg  <= is_store ? wdata_next : 32'h0;
                            funct3_reg <= minst_i[2:0];
                            off_reg    <= eff_off;
                            rd_reg     <= rd_i;
                            rdm_v_reg  <= rdm_v_i;
                        end
                    end else if (rdm_v_i) begin
                        wb_v_reg    <= 1'b1;
                        wb_rd_reg   <= rd_i;
                        wb_data_reg <= addr_i;
                    end
                end
                REQ: begin
                    if (dmem_gnt_i) begin
                        req_reg   <= 1'b0;
                        we_reg    <= 1'b0;
                        be_reg    <= 4'b0;
                        wdata_reg <= 32'h0;
                        if (we_reg) begin
                            state_reg <= IDLE;
                        end else if (dmem_rvalid_i) begin
                            state_reg   <= IDLE;
                            wb_v_reg    <= rdm_v_reg;
                            wb_rd_reg   <= rd_reg;
                            wb_data_reg <= load_val;
                        end else begin
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_rvalid_i) begin
                        state_reg   <= IDLE;
                        wb_v_reg    <= rdm_v_reg;
                        wb_rd_reg   <= rd_reg;
                        wb_data_reg <= load_val;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign stall_o      = (state_reg != IDLE);
    assign dmem_req_o   = req_reg;
    assign dmem_we_o    = we_reg;
    assign dmem_addr_o  = addr_reg;
    assign dmem_be_o    = be_reg;
    assign dmem_wdata_o = wdata_reg;
    assign wb_v_o       = wb_v_reg;
    assign wb_rd_o      = wb_rd_reg;
    assign wb_data_o    = wb_data_reg;
    assign err_o        = err_reg;
endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: pass-through, loads, stores, error ops and reset recovery.
module tb_memory_access;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  minst_i;
    logic [31:0] addr_i, wdata_i;
    logic [4:0]  rd_i;
    logic        rdm_v_i;
    logic        stall_o, dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_v_o, err_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;

    int n_checks = 0;
    int n_pass   = 0;
    int cycles;

    memory_access dut (
        .clk(clk), .reset(reset), .minst_i(minst_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .rd_i(rd_i), .rdm_v_i(rdm_v_i), .stall_o(stall_o), .dmem_req_o(dmem_req_o),
        .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i(dmem_rdata_i), .wb_v_o(wb_v_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else begin
            n_pass++;
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        minst_i = 4'b1100;
        rdm_v_i = 1'b0;
        addr_i  = 32'h0;
        wdata_i = 32'h0;
        rd_i    = 5'd0;
    endtask

    // Present one op for a single accept edge, then return inputs to idle
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rd, input logic rv);
        minst_i = op; addr_i = a; wdata_i = wd; rd_i = rd; rdm_v_i = rv;
        tick();
        idle_inputs();
    endtask

    // Drive bus responses by cycle index while stalled; returns number of stall cycles
    task automatic run_bus(input int gnt_at, input int rv_at, input int stray_rv, output int n);
        n = 0;
        while (stall_o && n < 20) begin
            n++;
            dmem_gnt_i    = (n == gnt_at);
            dmem_rvalid_i = (n == rv_at) || (n == stray_rv);
            tick();
        end
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
        tick(); tick();
        check("rst_stall", stall_o, 0);
        check("rst_req", dmem_req_o, 0);
        check("rst_we", dmem_we_o, 0);
        check("rst_be", dmem_be_o, 0);
        check("rst_wbv", wb_v_o, 0);
        check("rst_err", err_o, 0);
        reset = 1'b0;
        tick();

        // Pass-through
        issue(4'b1100, 32'h12345678, 32'h0, 5'd5, 1'b1);
        check("pt_wbv", wb_v_o, 1);
        check("pt_rd", wb_rd_o, 5);
        check("pt_data", wb_data_o, 32'h12345678);
        check("pt_stall", stall_o, 0);
        tick();
        check("pt_wbv_drop", wb_v_o, 0);

        // LB sign-extended, gnt on 3rd REQ cycle, rvalid in WAIT; stray rvalid in REQ ignored
        dmem_rdata_i = 32'h80FFFFFF;
        issue(4'b0000, 32'h00000103, 32'h0, 5'd7, 1'b1);
        check("lb_req", dmem_req_o, 1);
        check("lb_we", dmem_we_o, 0);
        check("lb_be", dmem_be_o, 4'b1000);
        check("lb_addr", dmem_addr_o, 32'h100);
        run_bus(3, 4, 1, cycles);
        check("lb_stall_cycles", cycles, 4);
        check("lb_wbv", wb_v_o, 1);
        check("lb_rd", wb_rd_o, 7);
        check("lb_data", wb_data_o, 32'hFFFFFF80);
        check("lb_req_drop", dmem_req_o, 0);

        // LHU with gnt and rvalid together
        dmem_rdata_i = 32'hBEEF0000;
        issue(4'b0101, 32'h00000102, 32'h0, 5'd9, 1'b1);
        check("lhu_be", dmem_be_o, 4'b1100);
        run_bus(1, 1, 0, cycles);
        check("lhu_stall_cycles", cycles, 1);
        check("lhu_wbv", wb_v_o, 1);
        check("lhu_data", wb_data_o, 32'h0000BEEF);

        // LH sign-extended upper halfword
        dmem_rdata_i = 32'h80010000;
        issue(4'b0001, 32'h00000302, 32'h0, 5'd10, 1'b1);
        run_bus(1, 2, 0, cycles);
        check("lh_data", wb_data_o, 32'hFFFF8001);

        // LBU byte lane 2
        dmem_rdata_i = 32'h00AB0000;
        issue(4'b0100, 32'h00000102, 32'h0, 5'd11, 1'b1);
        check("lbu_be", dmem_be_o, 4'b0100);
        run_bus(1, 1, 0, cycles);
        check("lbu_data", wb_data_o, 32'h000000AB);

        // LW to x0: bus read happens, no writeback
        dmem_rdata_i = 32'h11223344;
        issue(4'b0010, 32'h00000300, 32'h0, 5'd0, 1'b0);
        check("lw0_req", dmem_req_o, 1);
        check("lw0_be", dmem_be_o, 4'b1111);
        run_bus(2, 2, 0, cycles);
        check("lw0_stall_cycles", cycles, 2);
        check("lw0_wbv", wb_v_o, 0);

        // SB lane replication
        issue(4'b1000, 32'h00000201, 32'h000000A5, 5'd4, 1'b1);
        check("sb_we", dmem_we_o, 1);
        check("sb_be", dmem_be_o, 4'b0010);
        check("sb_wdata", dmem_wdata_o, 32'hA5A5A5A5);
        check("sb_addr", dmem_addr_o, 32'h200);
        run_bus(2, 0, 0, cycles);
        check("sb_stall_cycles", cycles, 2);
        check("sb_wbv", wb_v_o, 0);
        check("sb_idle_we", dmem_we_o, 0);
        check("sb_idle_be", dmem_be_o, 0);
        check("sb_idle_wdata", dmem_wdata_o, 0);

        // SH lane replication
        issue(4'b1001, 32'h00000002, 32'h0000CAFE, 5'd4, 1'b1);
        check("sh_be", dmem_be_o, 4'b1100);
        check("sh_wdata", dmem_wdata_o, 32'hCAFECAFE);
        run_bus(1, 0, 0, cycles);

        // Misaligned SW
        issue(4'b1010, 32'h00000202, 32'hDEADBEEF, 5'd0, 1'b0);
        check("mis_err", err_o, 1);
        check("mis_req", dmem_req_o, 0);
        check("mis_stall", stall_o, 0);
        tick();
        check("mis_err_drop", err_o, 0);

        // Reserved load funct3 011 and reserved store size 11
        issue(4'b0011, 32'h00000000, 32'h0, 5'd3, 1'b1);
        check("rsv_ld_err", err_o, 1);
        check("rsv_ld_stall", stall_o, 0);
        check("rsv_ld_wbv", wb_v_o, 0);
        issue(4'b1011, 32'h00000000, 32'h0, 5'd3, 1'b1);
        check("rsv_st_err", err_o, 1);
        check("rsv_st_req", dmem_req_o, 0);

        // Reset in WAIT, then a stale rvalid
        dmem_rdata_i = 32'h55555555;
        issue(4'b0010, 32'h00000400, 32'h0, 5'd3, 1'b1);
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        check("rw_wait_stall", stall_o, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rw_stall", stall_o, 0);
        check("rw_req", dmem_req_o, 0);
        dmem_rvalid_i = 1'b1;
        tick();
        dmem_rvalid_i = 1'b0;
        check("rw_wbv", wb_v_o, 0);
        check("rw_stall_after", stall_o, 0);

        // Reset in REQ drops the request
        issue(4'b0010, 32'h00000500, 32'h0, 5'd3, 1'b1);
        check("rr_req_before", dmem_req_o, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rr_req", dmem_req_o, 0);
        check("rr_stall", stall_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
